// File: rtl/licznik_chk.sv
// licznik_chk: cycle-accurate sequence checker for a loadable up-counter.
// Each edge it predicts the counter's next value (preset on load, else +1),
// compares the observed value with the previous prediction, and reports
// lock status, correctly predicted wraps and a saturating mismatch count.
module licznik_chk #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] i_Q,
    input  logic [WIDTH-1:0] cnt,
    input  logic             i_clr,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_wrap,
    output logic [ERR_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]       LOCK_N_C = 8'(LOCK_N);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};

    state_t           state_q, state_d;
    logic [7:0]       run_q, run_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             exp_inc_q, exp_inc_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic             match_s;
    logic [7:0]       run_inc_s;

    assign match_s   = (cnt == exp_q);
    assign run_inc_s = run_q + 8'd1;

    // State and output registers; reset forces SYNC with all outputs low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_SYNC;
            run_q     <= 8'd0;
            exp_q     <= W_ZERO;
            exp_inc_q <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            wrap_q    <= 1'b0;
            err_cnt_q <= ERR_ZERO;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            exp_q     <= exp_d;
            exp_inc_q <= exp_inc_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            wrap_q    <= wrap_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next-state logic: lock after LOCK_N consecutive matches, drop to CHECK on a miss.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            ST_SYNC: begin
                state_d = ST_CHECK;
                run_d   = 8'd0;
            end
            ST_CHECK: begin
                if (match_s) begin
                    run_d = run_inc_s;
                    if (run_inc_s >= LOCK_N_C) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    run_d   = 8'd0;
                    state_d = ST_CHECK;
                end
            end
            ST_LOCKED: begin
                if (match_s) begin
                    state_d = ST_LOCKED;
                    run_d   = run_q;
                end else begin
                    state_d = ST_CHECK;
                    run_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_SYNC;
                run_d   = 8'd0;
            end
        endcase
    end

    // Prediction of the counter's next value, refreshed on every edge in every state.
    always_comb begin
        exp_d     = W_ZERO;
        exp_inc_d = 1'b0;
        if (load) begin
            exp_d     = i_Q;
            exp_inc_d = 1'b0;
        end else begin
            exp_d     = cnt + W_ONE;
            exp_inc_d = (cnt == ALL_ONES);
        end
    end

    // Output logic: lock flag, error/wrap pulses and the saturating error count.
    always_comb begin
        locked_d  = (state_d == ST_LOCKED);
        err_d     = (state_q == ST_LOCKED) && !match_s;
        wrap_d    = (state_q == ST_LOCKED) && match_s && exp_inc_q && (exp_q == W_ZERO);
        err_cnt_d = err_cnt_q;
        if (i_clr) begin
            // Clear wins over a coincident increment; o_err still pulses.
            err_cnt_d = ERR_ZERO;
        end else if (err_d && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    assign o_locked  = locked_q;
    assign o_err     = err_q;
    assign o_wrap    = wrap_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_licznik_chk.sv
// Bench for licznik_chk: a directed vector table on the default instance,
// a hand-written saturation/clear sequence on a LOCK_N=1, ERR_W=2 instance,
// then random stimulus on both, checked against a behavioural model.
module tb_licznik_chk;

    logic       clk = 1'b0;
    // instance A: defaults (WIDTH=4, LOCK_N=4, ERR_W=8)
    logic       a_rst_n, a_load, a_clr;
    logic [3:0] a_iq, a_cnt;
    logic       a_locked, a_err, a_wrap;
    logic [7:0] a_ecnt;
    // instance B: LOCK_N=1, ERR_W=2
    logic       b_rst_n, b_load, b_clr;
    logic [3:0] b_iq, b_cnt;
    logic       b_locked, b_err, b_wrap;
    logic [1:0] b_ecnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    licznik_chk #(.WIDTH(4), .LOCK_N(4), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .load(a_load), .i_Q(a_iq), .cnt(a_cnt),
        .i_clr(a_clr), .o_locked(a_locked), .o_err(a_err), .o_wrap(a_wrap),
        .o_err_cnt(a_ecnt)
    );

    licznik_chk #(.WIDTH(4), .LOCK_N(1), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .load(b_load), .i_Q(b_iq), .cnt(b_cnt),
        .i_clr(b_clr), .o_locked(b_locked), .o_err(b_err), .o_wrap(b_wrap),
        .o_err_cnt(b_ecnt)
    );

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] iq;
        logic [3:0] c;
        logic       clr;
        logic       lk;
        logic       er;
        logic       wr;
        int         ec;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model: remembers what the counter should show next and how
    // many correct values in a row have been seen.
    typedef struct {
        bit have;     // a prediction exists
        int pred;     // value the counter should show next
        bit pwrap;    // that prediction came from 15 rolling over
        int streak;   // consecutive correct values while not locked
        bit locked;
        bit err;
        bit wrap;
        int ecnt;
    } mdl_t;

    function automatic mdl_t mstep(mdl_t m, bit rst, bit ld, int iq, int c, bit clr,
                                   int lockn, int emax);
        mdl_t r;
        r = m;
        if (!rst) begin
            r = '{default: 0};
            return r;
        end
        r.err  = 1'b0;
        r.wrap = 1'b0;
        if (r.have) begin
            if (r.locked) begin
                if (c == r.pred) begin
                    r.wrap = r.pwrap;
                end else begin
                    r.err    = 1'b1;
                    r.locked = 1'b0;
                    r.streak = 0;
                    if (r.ecnt < emax) r.ecnt = r.ecnt + 1;
                end
            end else if (c == r.pred) begin
                r.streak = r.streak + 1;
                if (r.streak >= lockn) r.locked = 1'b1;
            end else begin
                r.streak = 0;
            end
        end
        r.have  = 1'b1;
        r.pred  = ld ? iq : (c + 1) % 16;
        r.pwrap = !ld && (c == 15);
        if (clr) r.ecnt = 0;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic add(input bit r, input bit ld, input int iq, input int c, input bit clr,
                       input bit lk, input bit er, input bit wr, input int ec);
        vec_t v;
        v.rst = r; v.ld = ld; v.iq = 4'(iq); v.c = 4'(c); v.clr = clr;
        v.lk = lk; v.er = er; v.wr = wr; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic b_step(input string nm, input bit ld, input int iq, input int c, input bit clr,
                          input bit lk, input bit er, input bit wr, input int ec);
        b_rst_n = 1'b1; b_load = ld; b_iq = 4'(iq); b_cnt = 4'(c); b_clr = clr;
        step();
        chk({nm, " locked"}, int'(b_locked), int'(lk));
        chk({nm, " err"},    int'(b_err),    int'(er));
        chk({nm, " wrap"},   int'(b_wrap),   int'(wr));
        chk({nm, " errcnt"}, int'(b_ecnt),   ec);
    endtask

    initial begin
        mdl_t ma, mb;
        int   v, ctr;
        bit   r, ld, clr;
        int   iq, c;

        a_rst_n = 1'b0; a_load = 1'b0; a_iq = 4'd0; a_cnt = 4'd0; a_clr = 1'b0;
        b_rst_n = 1'b0; b_load = 1'b0; b_iq = 4'd0; b_cnt = 4'd0; b_clr = 1'b0;

        // ---- directed table for instance A ----
        add(0,0,0,0,0, 0,0,0,0);                       // reset
        add(1,1,6,0,0, 0,0,0,0);                       // capture preset 6
        add(1,0,0,6,0, 0,0,0,0);
        add(1,0,0,7,0, 0,0,0,0);
        add(1,0,0,8,0, 0,0,0,0);
        add(1,0,0,9,0, 1,0,0,0);                       // 4th match: lock
        for (int k = 10; k <= 15; k++) add(1,0,0,k,0, 1,0,0,0);
        add(1,0,0,0,0, 1,0,1,0);                       // wrap pulse
        add(1,0,0,1,0, 1,0,0,0);
        for (int k = 2; k <= 7; k++) add(1,0,0,k,0, 1,0,0,0);
        add(1,0,0,9,0, 0,1,0,1);                       // skipped 8
        add(1,0,0,10,0, 0,0,0,1);
        add(1,0,0,11,0, 0,0,0,1);
        add(1,0,0,12,0, 0,0,0,1);
        add(1,0,0,13,0, 1,0,0,1);                      // relock
        add(1,1,5,14,0, 1,0,0,1);                      // preset 5
        add(1,1,3,5,0, 1,0,0,1);                       // at 5, preset 3
        add(1,0,0,3,0, 1,0,0,1);                       // 3 accepted
        add(1,0,0,4,0, 1,0,0,1);
        add(1,0,0,5,0, 1,0,0,1);                       // at 5, no load
        add(1,0,0,3,0, 0,1,0,2);                       // 3 is an error
        add(1,0,0,4,0, 0,0,0,2);
        add(1,0,0,5,0, 0,0,0,2);
        add(1,0,0,6,0, 0,0,0,2);
        add(1,0,0,7,0, 1,0,0,2);                       // locked, errcnt 2
        add(0,0,0,8,1, 0,0,0,0);                       // reset mid-run
        add(1,0,0,8,0, 0,0,0,0);                       // SYNC capture
        add(1,0,0,3,0, 0,0,0,0);                       // miss in CHECK: silent
        add(1,0,0,4,0, 0,0,0,0);
        add(1,0,0,5,0, 0,0,0,0);
        add(1,0,0,6,0, 0,0,0,0);
        add(1,0,0,7,0, 1,0,0,0);                       // relock

        for (int i = 0; i < tbl.size(); i++) begin
            a_rst_n = tbl[i].rst; a_load = tbl[i].ld; a_iq = tbl[i].iq;
            a_cnt = tbl[i].c; a_clr = tbl[i].clr;
            step();
            chk($sformatf("A row %0d locked", i), int'(a_locked), int'(tbl[i].lk));
            chk($sformatf("A row %0d err", i),    int'(a_err),    int'(tbl[i].er));
            chk($sformatf("A row %0d wrap", i),   int'(a_wrap),   int'(tbl[i].wr));
            chk($sformatf("A row %0d errcnt", i), int'(a_ecnt),   tbl[i].ec);
        end

        // ---- instance B: saturation and clear (held in reset so far) ----
        chk("B reset locked", int'(b_locked), 0);
        chk("B reset errcnt", int'(b_ecnt), 0);
        b_step("B sync", 1, 0, 0, 0, 0, 0, 0, 0);
        b_step("B lock", 0, 0, 0, 0, 1, 0, 0, 0);
        v = 1;
        for (int k = 1; k <= 5; k++) begin
            b_step($sformatf("B miss%0d", k), 0, 0, (v + 5) % 16, 0, 0, 1, 0, (k < 3) ? k : 3);
            v = (v + 6) % 16;
            b_step($sformatf("B good%0d", k), 0, 0, v, 0, 1, 0, 0, (k < 3) ? k : 3);
            v = (v + 1) % 16;
        end
        b_step("B clr", 0, 0, v, 1, 1, 0, 0, 0);
        v = (v + 1) % 16;
        b_step("B clr+miss", 0, 0, (v + 3) % 16, 1, 0, 1, 0, 0);
        v = (v + 4) % 16;
        b_step("B 2nd miss", 0, 0, (v + 2) % 16, 0, 0, 0, 0, 0);
        v = (v + 3) % 16;
        b_step("B relock", 0, 0, v, 0, 1, 0, 0, 0);

        // ---- random stimulus on both instances against the model ----
        ma = '{default: 0};
        mb = '{default: 0};
        ctr = 0;
        for (int n = 0; n < 600; n++) begin
            r   = (n == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            ld  = ($urandom_range(0, 9) == 0);
            iq  = int'($urandom_range(0, 15));
            clr = ($urandom_range(0, 29) == 0);
            c   = ctr;
            if ($urandom_range(0, 19) == 0) c = (ctr + int'($urandom_range(1, 15))) % 16;
            ctr = ld ? iq : (c + 1) % 16;

            a_rst_n = r; a_load = ld; a_iq = 4'(iq); a_cnt = 4'(c); a_clr = clr;
            b_rst_n = r; b_load = ld; b_iq = 4'(iq); b_cnt = 4'(c); b_clr = clr;
            ma = mstep(ma, r, ld, iq, c, clr, 4, 255);
            mb = mstep(mb, r, ld, iq, c, clr, 1, 3);
            step();
            chk($sformatf("rnd %0d A locked", n), int'(a_locked), int'(ma.locked));
            chk($sformatf("rnd %0d A err", n),    int'(a_err),    int'(ma.err));
            chk($sformatf("rnd %0d A wrap", n),   int'(a_wrap),   int'(ma.wrap));
            chk($sformatf("rnd %0d A errcnt", n), int'(a_ecnt),   ma.ecnt);
            chk($sformatf("rnd %0d B locked", n), int'(b_locked), int'(mb.locked));
            chk($sformatf("rnd %0d B err", n),    int'(b_err),    int'(mb.err));
            chk($sformatf("rnd %0d B wrap", n),   int'(b_wrap),   int'(mb.wrap));
            chk($sformatf("rnd %0d B errcnt", n), int'(b_ecnt),   mb.ecnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
